// File: rtl/writer_pkg.sv
// Shared widths and the snapshot record type for the accumulator writer path.
package writer_pkg;

    localparam int DWIDTH    = 8;
    localparam int VWIDTH    = 4;
    localparam int ACC_RES_W = VWIDTH + DWIDTH + 1;

    typedef struct packed {
        logic [VWIDTH-1:0] cnt;
        logic [DWIDTH:0]   sum;
    } acc_res_t;

endpackage

// File: rtl/acc_result_fifo_if.sv
// Read-side bundle of the result FIFO. The master drives rd_valid/rd_data/level/ovf.
// A head entry moves when rd_valid && rd_ready are both high at a rising clk edge.
// rd_valid never depends on rd_ready, and rd_data is held while rd_valid && !rd_ready.
interface acc_result_fifo_if #(
    parameter int DWIDTH = writer_pkg::DWIDTH,
    parameter int VWIDTH = writer_pkg::VWIDTH,
    parameter int DEPTH  = 4
) ();

    logic                       rd_valid;
    logic                       rd_ready;
    logic [VWIDTH+DWIDTH:0]     rd_data;
    logic [$clog2(DEPTH):0]     level;
    logic                       ovf;

    modport master (
        output rd_valid,
        output rd_data,
        output level,
        output ovf,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        input  level,
        input  ovf,
        output rd_ready
    );

endinterface

// File: rtl/acc_res_ptr.sv
// Read/write pointers with a wrap bit. Derives full/empty from the pointers and keeps a
// registered occupancy count.
module acc_res_ptr #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_clear,
    input  logic                   i_push,
    input  logic                   i_pop,
    output logic [$clog2(DEPTH):0] o_wptr,
    output logic [$clog2(DEPTH):0] o_rptr,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_level;
    logic [PW-1:0] w_wptr_nxt;
    logic [PW-1:0] w_rptr_nxt;

    always_comb begin
        w_wptr_nxt = r_wptr;
        w_rptr_nxt = r_rptr;
        if (i_push) w_wptr_nxt = r_wptr + PW'(1);
        if (i_pop)  w_rptr_nxt = r_rptr + PW'(1);
    end

    // Level is wptr-rptr modulo 2^PW, registered in step with the pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_level <= w_wptr_nxt - w_rptr_nxt;
        end
    end

    assign o_wptr  = r_wptr;
    assign o_rptr  = r_rptr;
    assign o_level = r_level;
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);

endmodule

// File: rtl/acc_result_fifo.sv
// Snapshot FIFO behind the accumulator: captures {cnt, out} on snap and drains over valid/ready.
// Build option ACC_RES_DROPCNT_EN adds a saturating 8-bit drop counter output.
module acc_result_fifo #(
    parameter int DWIDTH = writer_pkg::DWIDTH,
    parameter int VWIDTH = writer_pkg::VWIDTH,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                snap,
    input  logic [DWIDTH:0]     acc_out,
    input  logic [VWIDTH-1:0]   acc_cnt,
`ifdef ACC_RES_DROPCNT_EN
    acc_result_fifo_if.master   rd_if,
    output logic [7:0]          drop_cnt
`else
    acc_result_fifo_if.master   rd_if
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int RW = VWIDTH + DWIDTH + 1;

    logic [RW-1:0] r_mem [DEPTH];
    logic [RW-1:0] r_rd_data;
    logic          r_ovf;

    logic [PW-1:0] w_wptr;
    logic [PW-1:0] w_rptr;
    logic [PW-1:0] w_level;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic [RW-1:0] w_din;
    logic [AW-1:0] w_rd_idx_nxt;

    assign w_din        = {acc_cnt, acc_out};
    assign w_pop        = !w_empty && rd_if.rd_ready && !clear;
    assign w_push       = snap && (!w_full || w_pop) && !clear;
    assign w_drop       = snap && w_full && !w_pop && !clear;
    assign w_rd_idx_nxt = w_rptr[AW-1:0] + AW'(1);

    acc_res_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (clear),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .o_wptr  (w_wptr),
        .o_rptr  (w_rptr),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (w_push) r_mem[w_wptr[AW-1:0]] <= w_din;
    end

    // Head register: the entry after the head is still in memory unless it is being
    // written this very cycle (level 1 with a simultaneous push), then take it from the input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (!clear) begin
            if (w_push && w_empty) begin
                r_rd_data <= w_din;
            end else if (w_pop) begin
                if (w_level == PW'(1)) begin
                    if (w_push) r_rd_data <= w_din;
                end else begin
                    r_rd_data <= r_mem[w_rd_idx_nxt];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_ovf <= 1'b0;
        else if (clear)  r_ovf <= 1'b0;
        else if (w_drop) r_ovf <= 1'b1;
    end

`ifdef ACC_RES_DROPCNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 r_drop_cnt <= '0;
        else if (clear)                             r_drop_cnt <= '0;
        else if (w_drop && (r_drop_cnt != 8'hFF))   r_drop_cnt <= r_drop_cnt + 8'd1;
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign rd_if.rd_valid = !w_empty;
    assign rd_if.rd_data  = r_rd_data;
    assign rd_if.level    = w_level;
    assign rd_if.ovf      = r_ovf;

endmodule

// File: tb/tb_acc_result_fifo.sv
// Directed bench for acc_result_fifo (DWIDTH=8, VWIDTH=4, DEPTH=4); drop counter checks
// are compiled when ACC_RES_DROPCNT_EN is defined.
module tb_acc_result_fifo;
    import writer_pkg::*;

    localparam int DW = 8;
    localparam int VW = 4;
    localparam int DP = 4;
    localparam int W  = VW + DW + 1;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          snap;
    logic [DW:0]   acc_out;
    logic [VW-1:0] acc_cnt;
`ifdef ACC_RES_DROPCNT_EN
    logic [7:0]    drop_cnt;
`endif

    int errors;
    int checks;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp;

    acc_result_fifo_if #(.DWIDTH(DW), .VWIDTH(VW), .DEPTH(DP)) rif ();

    acc_result_fifo #(.DWIDTH(DW), .VWIDTH(VW), .DEPTH(DP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .snap     (snap),
        .acc_out  (acc_out),
        .acc_cnt  (acc_cnt),
`ifdef ACC_RES_DROPCNT_EN
        .rd_if    (rif.master),
        .drop_cnt (drop_cnt)
`else
        .rd_if    (rif.master)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pack(input logic [VW-1:0] c, input logic [DW:0] s);
        acc_res_t t;
        t.cnt = c;
        t.sum = s;
        return t;
    endfunction

    // Driver: fill with n snaps starting at value base, rd_ready low, recording expectations.
    task automatic fill(input int base, input int n);
        rif.rd_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            snap    = 1'b1;
            acc_out = 9'(base + i);
            acc_cnt = 4'(base + i);
            exp_q.push_back(pack(4'(base + i), 9'(base + i)));
            cyc();
        end
        snap = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (rif.rd_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b want=0", rif.rd_valid); end
        checks++; if (rif.level !== 3'd0) begin errors++; $display("FAIL rst_level got=%0d want=0", rif.level); end
        checks++; if (rif.ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%0b want=0", rif.ovf); end
        checks++; if (rif.rd_data !== 13'h0) begin errors++; $display("FAIL rst_data got=%h want=0", rif.rd_data); end
        fill(1, 5);
        exp_q.delete();
        checks++; if (rif.level !== 3'd4 || rif.ovf !== 1'b1) begin errors++; $display("FAIL pre_rst level=%0d ovf=%0b want 4/1", rif.level, rif.ovf); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rif.rd_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%0b want=0", rif.rd_valid); end
        checks++; if (rif.level !== 3'd0) begin errors++; $display("FAIL mid_rst_level got=%0d want=0", rif.level); end
        checks++; if (rif.ovf !== 1'b0) begin errors++; $display("FAIL mid_rst_ovf got=%0b want=0", rif.ovf); end
        checks++; if (rif.rd_data !== 13'h0) begin errors++; $display("FAIL mid_rst_data got=%h want=0", rif.rd_data); end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        snap = 1'b1; acc_cnt = 4'd3; acc_out = 9'h1FE; rif.rd_ready = 1'b1;
        #1;
        checks++; if (rif.rd_valid !== 1'b0) begin errors++; $display("FAIL single_bypass got=%0b want=0", rif.rd_valid); end
        cyc();
        snap = 1'b0;
        checks++; if (rif.rd_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%0b want=1", rif.rd_valid); end
        checks++; if (rif.rd_data !== 13'h07FE) begin errors++; $display("FAIL single_data got=%h want=07fe", rif.rd_data); end
        checks++; if (rif.level !== 3'd1) begin errors++; $display("FAIL single_level got=%0d want=1", rif.level); end
        cyc();
        rif.rd_ready = 1'b0;
        checks++; if (rif.rd_valid !== 1'b0 || rif.level !== 3'd0) begin errors++; $display("FAIL single_pop valid=%0b level=%0d want 0/0", rif.rd_valid, rif.level); end
    endtask

    task automatic test_fill();
        fill(1, 4);
        checks++; if (rif.level !== 3'd4 || rif.ovf !== 1'b0) begin errors++; $display("FAIL fill_full level=%0d ovf=%0b want 4/0", rif.level, rif.ovf); end
        snap = 1'b1; acc_out = 9'd5; acc_cnt = 4'd5;
        cyc();
        snap = 1'b0;
        checks++; if (rif.level !== 3'd4) begin errors++; $display("FAIL drop_level got=%0d want=4", rif.level); end
        checks++; if (rif.ovf !== 1'b1) begin errors++; $display("FAIL drop_ovf got=%0b want=1", rif.ovf); end
        checks++; if (rif.rd_data !== 13'h0201) begin errors++; $display("FAIL drop_hold got=%h want=0201", rif.rd_data); end
        rif.rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = exp_q.pop_front();
            checks++; if (rif.rd_valid !== 1'b1 || rif.rd_data !== exp) begin errors++; $display("FAIL drain_%0d valid=%0b got=%h want=%h", i, rif.rd_valid, rif.rd_data, exp); end
            cyc();
        end
        rif.rd_ready = 1'b0;
        checks++; if (rif.rd_valid !== 1'b0 || rif.level !== 3'd0) begin errors++; $display("FAIL drain_empty valid=%0b level=%0d want 0/0", rif.rd_valid, rif.level); end
        checks++; if (rif.ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0b want=1", rif.ovf); end
    endtask

    task automatic test_full_snap_pop();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        checks++; if (rif.ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf got=%0b want=0", rif.ovf); end
        fill(10, 4);
        snap = 1'b1; acc_out = 9'd14; acc_cnt = 4'd14; rif.rd_ready = 1'b1;
        exp_q.push_back(pack(4'd14, 9'd14));
        exp = exp_q.pop_front();
        checks++; if (rif.rd_data !== exp) begin errors++; $display("FAIL fsp_head got=%h want=%h", rif.rd_data, exp); end
        cyc();
        snap = 1'b0; rif.rd_ready = 1'b0;
        checks++; if (rif.level !== 3'd4 || rif.ovf !== 1'b0) begin errors++; $display("FAIL fsp_state level=%0d ovf=%0b want 4/0", rif.level, rif.ovf); end
        rif.rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = exp_q.pop_front();
            checks++; if (rif.rd_valid !== 1'b1 || rif.rd_data !== exp) begin errors++; $display("FAIL fsp_drain_%0d valid=%0b got=%h want=%h", i, rif.rd_valid, rif.rd_data, exp); end
            cyc();
        end
        rif.rd_ready = 1'b0;
        checks++; if (rif.level !== 3'd0) begin errors++; $display("FAIL fsp_empty got=%0d want=0", rif.level); end
    endtask

    task automatic test_clear();
        fill(20, 5);
        exp_q.delete();
        checks++; if (rif.ovf !== 1'b1) begin errors++; $display("FAIL clr_pre_ovf got=%0b want=1", rif.ovf); end
        rif.rd_ready = 1'b1;
        cyc();
        rif.rd_ready = 1'b0;
        checks++; if (rif.level !== 3'd3) begin errors++; $display("FAIL clr_pre_level got=%0d want=3", rif.level); end
        clear = 1'b1; snap = 1'b1; acc_out = 9'h55;
        cyc();
        clear = 1'b0; snap = 1'b0;
        checks++; if (rif.level !== 3'd0 || rif.rd_valid !== 1'b0 || rif.ovf !== 1'b0) begin errors++; $display("FAIL clr_state level=%0d valid=%0b ovf=%0b want 0/0/0", rif.level, rif.rd_valid, rif.ovf); end
        cyc();
        checks++; if (rif.level !== 3'd0 || rif.rd_valid !== 1'b0) begin errors++; $display("FAIL clr_snap_lost level=%0d valid=%0b want 0/0", rif.level, rif.rd_valid); end
    endtask

    task automatic test_back_to_back();
        rif.rd_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            snap = 1'b1;
            acc_out = 9'(9'h100 + i * 37);
            acc_cnt = 4'(i + 1);
            exp = pack(4'(i + 1), 9'(9'h100 + i * 37));
            cyc();
            checks++; if (rif.rd_valid !== 1'b1 || rif.level !== 3'd1 || rif.rd_data !== exp) begin errors++; $display("FAIL b2b_%0d valid=%0b level=%0d got=%h want=%h", i, rif.rd_valid, rif.level, rif.rd_data, exp); end
        end
        snap = 1'b0;
        cyc();
        rif.rd_ready = 1'b0;
        checks++; if (rif.rd_valid !== 1'b0 || rif.level !== 3'd0) begin errors++; $display("FAIL b2b_end valid=%0b level=%0d want 0/0", rif.rd_valid, rif.level); end
    endtask

`ifdef ACC_RES_DROPCNT_EN
    task automatic test_drop_cnt();
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL dcnt_init got=%0d want=0", drop_cnt); end
        fill(1, 4);
        exp_q.delete();
        snap = 1'b1;
        repeat (300) cyc();
        snap = 1'b0;
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL dcnt_sat got=%0d want=255", drop_cnt); end
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL dcnt_clear got=%0d want=0", drop_cnt); end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        clear = 1'b0;
        snap = 1'b0;
        acc_out = '0;
        acc_cnt = '0;
        rif.rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        test_reset();
        test_single();
        test_fill();
        test_full_snap_pop();
        test_clear();
        test_back_to_back();
`ifdef ACC_RES_DROPCNT_EN
        test_drop_cnt();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
